// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the system-RAM arbiter: RAM geometry, requester
// indices and the lock FSM state encoding.
package mem_arbiter_pkg;

  localparam int MEM_AW = 5;
  localparam int MEM_DW = 16;

  localparam int REQ_LOADER = 0;
  localparam int REQ_CPU    = 1;
  localparam int REQ_DEBUG  = 2;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority encoder: picks the first set request at or after ptr_i,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  logic found;
  int   sel;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = IW'(sel);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin request/grant arbiter in front of the single-port system RAM,
// with bounded burst locking and per-requester read-response routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    lock_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*AW-1:0] addr_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic [2:0]            owner_o,
  output logic                  locked_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DW-1:0]         mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DW-1:0]         mem_rdata_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  lock_state_e                             state_q, state_d;
  logic [IW-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                           owner_q, owner_d;
  logic [CW-1:0]                           lock_cnt_q, lock_cnt_d;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]      rd_pipe_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      gnt_idx;
  logic               hold;
  logic               accept;
  logic [CW-1:0]      base_cnt;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx)
  );

  // The owner keeps the grant only while it still requests and still locks.
  always_comb begin
    hold    = (state_q == ST_LOCKED) && req_i[owner_q] && lock_i[owner_q];
    gnt_o   = '0;
    gnt_idx = pick_idx;
    if (reset_i) begin
      gnt_o = '0;
    end else if (hold) begin
      gnt_o[owner_q] = 1'b1;
      gnt_idx        = owner_q;
    end else begin
      gnt_o = pick_oh;
    end
    accept = |gnt_o;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) begin
        mem_addr_o  = addr_i[i*AW +: AW];
        mem_wdata_o = wdata_i[i*DW +: DW];
      end
    end
    mem_we_o = |(gnt_o & we_i);
  end

  // A fresh lock starts counting from zero; only a continuing owner accumulates.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    base_cnt   = '0;
    if (accept) begin
      rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      if ((state_q == ST_LOCKED) && (owner_q == gnt_idx)) base_cnt = lock_cnt_q;
      if (lock_i[gnt_idx] && (int'(base_cnt) + 1 < MAX_LOCK)) begin
        state_d    = ST_LOCKED;
        owner_d    = gnt_idx;
        lock_cnt_d = base_cnt + CW'(1);
      end else begin
        state_d    = ST_UNLOCKED;
        owner_d    = '0;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = ST_UNLOCKED;
      owner_d    = '0;
      lock_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_UNLOCKED;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rd_pipe_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pipe_q[0] <= gnt_o & ~we_i;
      for (int k = 1; k < RD_LATENCY; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
    end
  end

  // Responses in flight when reset arrives are suppressed in the reset cycle too.
  assign rvalid_o = reset_i ? '0 : rd_pipe_q[RD_LATENCY-1];
  assign rdata_o  = mem_rdata_i;
  assign locked_o = (state_q == ST_LOCKED);
  assign owner_o  = 3'(owner_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a write-first RAM model; expected grants
// and read responses are queued by the stimulus and checked by monitors.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, we;
  logic [4:0]  a [3];
  logic [15:0] d [3];
  logic [14:0] addr_bus;
  logic [47:0] wdata_bus;
  logic [2:0]  gnt, rvalid, owner;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;
  logic        mem_we, locked;
  logic [15:0] ram [32];

  typedef struct {
    logic [2:0]  gnt;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        we;
  } acc_t;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
  } rd_t;

  acc_t acc_q[$];
  rd_t  rd_q[$];
  acc_t acc_e;
  rd_t  rd_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign addr_bus  = {a[2], a[1], a[0]};
  assign wdata_bus = {d[2], d[1], d[0]};

  always #5 clock = ~clock;

  mem_arbiter #(.NUM_REQ(3), .AW(5), .DW(16), .RD_LATENCY(1), .MAX_LOCK(4)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_i       (req),
    .lock_i      (lock),
    .we_i        (we),
    .addr_i      (addr_bus),
    .wdata_i     (wdata_bus),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .owner_o     (owner),
    .locked_o    (locked),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  // Write-first single-port RAM, one cycle read latency.
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_acc(input int i, input logic w);
    acc_t e;
    e.gnt   = 3'(1 << i);
    e.addr  = a[i];
    e.wdata = d[i];
    e.we    = w;
    acc_q.push_back(e);
  endtask

  task automatic push_rd(input int i, input logic [15:0] data);
    rd_t e;
    e.id   = 3'(1 << i);
    e.data = data;
    rd_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (|(gnt & req)) begin
      if (acc_q.size() == 0) begin
        check("unexpected grant", 32'(gnt), 32'h0);
      end else begin
        acc_e = acc_q.pop_front();
        check("grant",     32'(gnt),       32'(acc_e.gnt));
        check("mem_addr",  32'(mem_addr),  32'(acc_e.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(acc_e.wdata));
        check("mem_we",    32'(mem_we),    32'(acc_e.we));
      end
    end
  end

  always @(negedge clock) begin
    if (|rvalid) begin
      if (rd_q.size() == 0) begin
        check("unexpected rvalid", 32'(rvalid), 32'h0);
      end else begin
        rd_e = rd_q.pop_front();
        check("rvalid id", 32'(rvalid), 32'(rd_e.id));
        check("rdata",     32'(rdata),  32'(rd_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req   = 3'b111;
    lock  = 3'b000;
    we    = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a[i] = 5'(10 + i);
      d[i] = 16'(16'h1000 + i);
    end

    // Reset held with all requests pending.
    repeat (2) begin
      @(negedge clock);
      check("reset gnt",    32'(gnt),    32'h0);
      check("reset rvalid", 32'(rvalid), 32'h0);
      check("reset mem_we", 32'(mem_we), 32'h0);
    end
    step();
    reset = 1'b0;

    // Round-robin with every requester writing.
    for (int r = 0; r < 6; r++) push_acc(r % 3, 1'b1);
    repeat (6) step();
    req = 3'b000;
    @(negedge clock);
    check("idle gnt",       32'(gnt),       32'h0);
    check("idle mem_addr",  32'(mem_addr),  32'h0);
    check("idle mem_wdata", 32'(mem_wdata), 32'h0);
    check("idle mem_we",    32'(mem_we),    32'h0);

    // Write then read-back by the CPU.
    step();
    req = 3'b010; we = 3'b010; a[REQ_CPU] = 5'd7; d[REQ_CPU] = 16'hBEEF;
    push_acc(REQ_CPU, 1'b1);
    step();
    we = 3'b000;
    push_acc(REQ_CPU, 1'b0);
    push_rd(REQ_CPU, 16'hBEEF);
    step();
    req = 3'b000;
    step();

    // Back-to-back reads from debug then loader (rr_ptr sits at 2).
    req = 3'b101; we = 3'b000; a[REQ_LOADER] = 5'd10; a[REQ_DEBUG] = 5'd12;
    push_acc(REQ_DEBUG, 1'b0);
    push_rd(REQ_DEBUG, 16'h1002);
    step();
    req = 3'b001;
    push_acc(REQ_LOADER, 1'b0);
    push_rd(REQ_LOADER, 16'h1000);
    step();
    req = 3'b000;
    repeat (2) step();

    // Lock cap of 4: loader locks while the CPU waits.
    a[0] = 5'd3; d[0] = 16'h0A0A; a[1] = 5'd4; d[1] = 16'h0B0B;
    we = 3'b011; lock = 3'b001;
    for (int k = 0; k < 5; k++) begin
      req = (k == 0) ? 3'b001 : 3'b011;
      push_acc((k == 4) ? REQ_CPU : REQ_LOADER, 1'b1);
      @(negedge clock);
      check("lock cap locked", 32'(locked), (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      step();
    end
    req = 3'b000; lock = 3'b000;
    step();

    // Debug owns a lock, then drops it while the loader waits.
    a[2] = 5'd5; d[2] = 16'h0C0C; we = 3'b101;
    req = 3'b100; lock = 3'b100;
    push_acc(REQ_DEBUG, 1'b1);
    step();
    req = 3'b101;
    push_acc(REQ_DEBUG, 1'b1);
    @(negedge clock);
    check("burst locked", 32'(locked), 32'h1);
    check("burst owner",  32'(owner),  32'h2);
    step();
    lock = 3'b000;
    push_acc(REQ_LOADER, 1'b1);
    @(negedge clock);
    check("release cycle locked", 32'(locked), 32'h1);
    check("release cycle owner",  32'(owner),  32'h2);
    step();
    req = 3'b100;
    push_acc(REQ_DEBUG, 1'b1);
    @(negedge clock);
    check("after release locked", 32'(locked), 32'h0);
    check("after release owner",  32'(owner),  32'h0);
    step();
    req = 3'b000;
    step();

    // Reset one cycle after an accepted, locked read.
    we = 3'b000; a[1] = 5'd7; req = 3'b010; lock = 3'b010;
    push_acc(REQ_CPU, 1'b0);
    step();
    reset = 1'b1; req = 3'b000; lock = 3'b000;
    @(negedge clock);
    check("reset mid-read rvalid", 32'(rvalid), 32'h0);
    check("reset mid-read gnt",    32'(gnt),    32'h0);
    step();
    reset = 1'b0; req = 3'b111; we = 3'b111;
    push_acc(REQ_LOADER, 1'b1);
    @(negedge clock);
    check("post-reset rvalid", 32'(rvalid), 32'h0);
    check("post-reset locked", 32'(locked), 32'h0);
    check("post-reset owner",  32'(owner),  32'h0);
    step();
    req = 3'b000; we = 3'b000;
    repeat (3) step();

    check("grants outstanding",    32'(acc_q.size()), 32'h0);
    check("responses outstanding", 32'(rd_q.size()),  32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
